// File: rtl/rot_ctrl.sv
// Rotation sequencer: walks the source image in raster order and issues one read
// and one rotated-address write per pixel over valid/ready handshakes.
module rot_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int BPP_LOG2 = 2
) (
    input  logic              I_ROTCTRL_PCLK,
    input  logic              I_ROTCTRL_PRESET_N,
    input  logic              I_ROTCTRL_START,
    input  logic              I_ROTCTRL_SOFT_RESET,
    input  logic [ADDR_W-1:0] I_ROTCTRL_SRC_IMG,
    input  logic [15:0]       I_ROTCTRL_IMG_H,
    input  logic [15:0]       I_ROTCTRL_IMG_W,
    input  logic [1:0]        I_ROTCTRL_MODE,
    input  logic              I_ROTCTRL_DIR,
    input  logic              I_ROTCTRL_INTR_MASK,
    input  logic              I_ROTCTRL_INTR_CLEAR,
    output logic              O_ROTCTRL_RD_VALID,
    output logic [ADDR_W-1:0] O_ROTCTRL_RD_ADDR,
    input  logic              I_ROTCTRL_RD_READY,
    input  logic              I_ROTCTRL_RD_DVALID,
    input  logic [DATA_W-1:0] I_ROTCTRL_RD_DATA,
    output logic              O_ROTCTRL_WR_VALID,
    output logic [ADDR_W-1:0] O_ROTCTRL_WR_ADDR,
    output logic [DATA_W-1:0] O_ROTCTRL_WR_DATA,
    input  logic              I_ROTCTRL_WR_READY,
    output logic [ADDR_W-1:0] O_ROTCTRL_DMA_DST_IMG,
    output logic [15:0]       O_ROTCTRL_NEW_H,
    output logic [15:0]       O_ROTCTRL_NEW_W,
    output logic              O_ROTCTRL_BUSY,
    output logic              O_ROTCTRL_DONE,
    output logic              O_ROTCTRL_INTR
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_NEXT, S_DONE
    } state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_src, r_dst;
    logic [15:0]       r_h, r_w, r_new_h, r_new_w, r_row, r_col;
    logic [1:0]        r_q;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_done_flag;

    logic [1:0]        w_q;
    logic [31:0]       w_area, w_src_idx, w_dst_idx;
    logic              w_start_ok, w_zero, w_last, w_col_end;
    logic [15:0]       w_rrev, w_crev, w_dr, w_dc;

    // Counter-clockwise turns fold onto clockwise: (4-MODE) mod 4 == -MODE mod 4.
    assign w_q        = I_ROTCTRL_DIR ? (2'd0 - I_ROTCTRL_MODE) : I_ROTCTRL_MODE;
    assign w_area     = 32'(I_ROTCTRL_IMG_H) * 32'(I_ROTCTRL_IMG_W);
    assign w_zero     = (I_ROTCTRL_IMG_H == 16'd0) || (I_ROTCTRL_IMG_W == 16'd0);
    assign w_start_ok = I_ROTCTRL_START && !I_ROTCTRL_SOFT_RESET && (r_state == S_IDLE);
    assign w_col_end  = (r_col == r_w - 16'd1);
    assign w_last     = w_col_end && (r_row == r_h - 16'd1);

    assign w_rrev = r_h - 16'd1 - r_row;
    assign w_crev = r_w - 16'd1 - r_col;

    always_comb begin
        w_dr = r_row;
        w_dc = r_col;
        case (r_q)
            2'd1:    begin w_dr = r_col;  w_dc = w_rrev; end
            2'd2:    begin w_dr = w_rrev; w_dc = w_crev; end
            2'd3:    begin w_dr = w_crev; w_dc = r_row;  end
            default: begin w_dr = r_row;  w_dc = r_col;  end
        endcase
    end

    assign w_src_idx = 32'(r_row) * 32'(r_w) + 32'(r_col);
    assign w_dst_idx = 32'(w_dr) * 32'(r_new_w) + 32'(w_dc);

    always_comb begin
        w_next = r_state;
        if (I_ROTCTRL_SOFT_RESET) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (I_ROTCTRL_START) w_next = w_zero ? S_DONE : S_RD_REQ;
                S_RD_REQ:  if (I_ROTCTRL_RD_READY) w_next = S_RD_WAIT;
                S_RD_WAIT: if (I_ROTCTRL_RD_DVALID) w_next = S_WR_REQ;
                S_WR_REQ:  if (I_ROTCTRL_WR_READY) w_next = S_NEXT;
                S_NEXT:    w_next = w_last ? S_DONE : S_RD_REQ;
                S_DONE:    w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_ROTCTRL_PCLK or negedge I_ROTCTRL_PRESET_N) begin
        if (!I_ROTCTRL_PRESET_N) r_state <= S_IDLE;
        else                     r_state <= w_next;
    end

    // Job configuration is frozen at START so register writes mid-job are harmless.
    always_ff @(posedge I_ROTCTRL_PCLK or negedge I_ROTCTRL_PRESET_N) begin
        if (!I_ROTCTRL_PRESET_N) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_h     <= '0;
            r_w     <= '0;
            r_q     <= '0;
            r_new_h <= '0;
            r_new_w <= '0;
        end else if (w_start_ok) begin
            r_src   <= I_ROTCTRL_SRC_IMG;
            r_dst   <= I_ROTCTRL_SRC_IMG + ADDR_W'(w_area << BPP_LOG2);
            r_h     <= I_ROTCTRL_IMG_H;
            r_w     <= I_ROTCTRL_IMG_W;
            r_q     <= w_q;
            r_new_h <= w_q[0] ? I_ROTCTRL_IMG_W : I_ROTCTRL_IMG_H;
            r_new_w <= w_q[0] ? I_ROTCTRL_IMG_H : I_ROTCTRL_IMG_W;
        end
    end

    always_ff @(posedge I_ROTCTRL_PCLK or negedge I_ROTCTRL_PRESET_N) begin
        if (!I_ROTCTRL_PRESET_N) begin
            r_row <= '0;
            r_col <= '0;
        end else if (I_ROTCTRL_SOFT_RESET || w_start_ok) begin
            r_row <= '0;
            r_col <= '0;
        end else if (r_state == S_NEXT) begin
            if (w_last) begin
                r_row <= '0;
                r_col <= '0;
            end else if (w_col_end) begin
                r_row <= r_row + 16'd1;
                r_col <= '0;
            end else begin
                r_col <= r_col + 16'd1;
            end
        end
    end

    always_ff @(posedge I_ROTCTRL_PCLK or negedge I_ROTCTRL_PRESET_N) begin
        if (!I_ROTCTRL_PRESET_N)
            r_wr_data <= '0;
        else if (r_state == S_RD_WAIT && I_ROTCTRL_RD_DVALID)
            r_wr_data <= I_ROTCTRL_RD_DATA;
    end

    // Completion set beats a coincident clear so a finishing job is never lost.
    always_ff @(posedge I_ROTCTRL_PCLK or negedge I_ROTCTRL_PRESET_N) begin
        if (!I_ROTCTRL_PRESET_N)            r_done_flag <= 1'b0;
        else if (I_ROTCTRL_SOFT_RESET)      r_done_flag <= 1'b0;
        else if (r_state == S_DONE)         r_done_flag <= 1'b1;
        else if (I_ROTCTRL_INTR_CLEAR)      r_done_flag <= 1'b0;
    end

    assign O_ROTCTRL_RD_VALID    = (r_state == S_RD_REQ);
    assign O_ROTCTRL_RD_ADDR     = r_src + ADDR_W'(w_src_idx << BPP_LOG2);
    assign O_ROTCTRL_WR_VALID    = (r_state == S_WR_REQ);
    assign O_ROTCTRL_WR_ADDR     = r_dst + ADDR_W'(w_dst_idx << BPP_LOG2);
    assign O_ROTCTRL_WR_DATA     = r_wr_data;
    assign O_ROTCTRL_DMA_DST_IMG = r_dst;
    assign O_ROTCTRL_NEW_H       = r_new_h;
    assign O_ROTCTRL_NEW_W       = r_new_w;
    assign O_ROTCTRL_BUSY        = (r_state != S_IDLE);
    assign O_ROTCTRL_DONE        = (r_state == S_DONE) && !I_ROTCTRL_SOFT_RESET;
    assign O_ROTCTRL_INTR        = r_done_flag && !I_ROTCTRL_INTR_MASK;

endmodule

// File: tb/tb_rot_ctrl.sv
// Directed bench for rot_ctrl: hand-computed address tables, handshake stalls,
// soft reset, zero-size jobs and interrupt set/clear/mask behaviour.
module tb_rot_ctrl;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 1'b0, srst = 1'b0, dir = 1'b0, mask = 1'b0, clr = 1'b0;
    logic [31:0] src = '0, rd_data = '0;
    logic [15:0] h = '0, w = '0;
    logic [1:0]  mode = '0;
    logic        rd_ready = 1'b0, dvalid = 1'b0, wr_ready = 1'b0;
    logic        rd_valid, wr_valid, busy, done, intr;
    logic [31:0] rd_addr, wr_addr, wr_data, dst;
    logic [15:0] new_h, new_w;

    int          n_tests = 0, n_fail = 0, max_stall = 0;
    logic [31:0] exp_rd[6], exp_wr[6];
    logic [31:0] a;

    rot_ctrl #(.ADDR_W(32), .DATA_W(32), .BPP_LOG2(2)) dut (
        .I_ROTCTRL_PCLK(clk), .I_ROTCTRL_PRESET_N(rst_n),
        .I_ROTCTRL_START(start), .I_ROTCTRL_SOFT_RESET(srst),
        .I_ROTCTRL_SRC_IMG(src), .I_ROTCTRL_IMG_H(h), .I_ROTCTRL_IMG_W(w),
        .I_ROTCTRL_MODE(mode), .I_ROTCTRL_DIR(dir),
        .I_ROTCTRL_INTR_MASK(mask), .I_ROTCTRL_INTR_CLEAR(clr),
        .O_ROTCTRL_RD_VALID(rd_valid), .O_ROTCTRL_RD_ADDR(rd_addr),
        .I_ROTCTRL_RD_READY(rd_ready), .I_ROTCTRL_RD_DVALID(dvalid),
        .I_ROTCTRL_RD_DATA(rd_data),
        .O_ROTCTRL_WR_VALID(wr_valid), .O_ROTCTRL_WR_ADDR(wr_addr),
        .O_ROTCTRL_WR_DATA(wr_data), .I_ROTCTRL_WR_READY(wr_ready),
        .O_ROTCTRL_DMA_DST_IMG(dst), .O_ROTCTRL_NEW_H(new_h), .O_ROTCTRL_NEW_W(new_w),
        .O_ROTCTRL_BUSY(busy), .O_ROTCTRL_DONE(done), .O_ROTCTRL_INTR(intr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick_stall();
        return (max_stall == 0) ? 0 : int'($urandom_range(0, max_stall));
    endfunction

    // Read handshake with stalls; DVALID pulses during the stall must be ignored.
    task automatic do_read(output logic [31:0] addr);
        int n = 0;
        int s = pick_stall();
        while (!rd_valid && n < 50) begin tick; n++; end
        chk("rd_valid_wait", rd_valid, 1);
        addr = rd_addr;
        repeat (s) begin
            dvalid = 1'b1; rd_data = 32'hDEAD_BEEF;
            tick;
            chk("rd_hold_valid", rd_valid, 1);
            chk("rd_hold_addr", rd_addr, addr);
        end
        dvalid = 1'b0;
        rd_ready = 1'b1; tick; rd_ready = 1'b0;
        repeat (pick_stall()) tick;
        dvalid = 1'b1; rd_data = addr ^ 32'hA5A5_0000;
        tick;
        dvalid = 1'b0; rd_data = 32'h0;
    endtask

    task automatic do_write(input logic [31:0] ea, input logic [31:0] ed);
        int n = 0;
        int s = pick_stall();
        while (!wr_valid && n < 50) begin tick; n++; end
        chk("wr_valid_wait", wr_valid, 1);
        chk("wr_addr", wr_addr, ea);
        chk("wr_data", wr_data, ed);
        repeat (s) begin
            tick;
            chk("wr_hold_valid", wr_valid, 1);
            chk("wr_hold_addr", wr_addr, ea);
            chk("wr_hold_data", wr_data, ed);
        end
        wr_ready = 1'b1; tick; wr_ready = 1'b0;
    endtask

    task automatic run_job(input int n);
        logic [31:0] ra;
        for (int i = 0; i < n; i++) begin
            do_read(ra);
            chk("rd_addr", ra, exp_rd[i]);
            do_write(exp_wr[i], exp_rd[i] ^ 32'hA5A5_0000);
        end
        chk("next_done_low", done, 0);
        chk("next_busy", busy, 1);
        tick;
        chk("done_pulse", done, 1);
        tick;
        chk("done_after", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic start_job;
        start = 1'b1; tick; start = 1'b0;
    endtask

    task automatic clear_intr;
        clr = 1'b1; tick; clr = 1'b0;
        chk("intr_cleared", intr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_intr", intr, 0);
        chk("rst_dst", dst, 0);
        chk("rst_new_h", new_h, 0);
        chk("rst_new_w", new_w, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        #9 rst_n = 1'b1;
        tick;

        // 2x3 image, one clockwise quarter turn, no stalls.
        src = 32'h1000; h = 16'd2; w = 16'd3; mode = 2'd1; dir = 1'b0;
        exp_rd = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h1014};
        exp_wr = '{32'h101C, 32'h1024, 32'h102C, 32'h1018, 32'h1020, 32'h1028};
        start_job;
        chk("t1_rd_valid_t1", rd_valid, 1);
        chk("t1_busy", busy, 1);
        chk("t1_dst", dst, 32'h1018);
        chk("t1_new_h", new_h, 3);
        chk("t1_new_w", new_w, 2);
        run_job(6);
        chk("t1_intr", intr, 1);
        tick;
        chk("t1_intr_held", intr, 1);
        clear_intr;

        // 3x2 image, half turn both directions; the write order must match.
        src = 32'h2000; h = 16'd3; w = 16'd2;
        exp_rd = '{32'h2000, 32'h2004, 32'h2008, 32'h200C, 32'h2010, 32'h2014};
        exp_wr = '{32'h202C, 32'h2028, 32'h2024, 32'h2020, 32'h201C, 32'h2018};
        for (int k = 0; k < 2; k++) begin
            mode = 2'd2; dir = (k == 0); max_stall = (k == 0) ? 5 : 0;
            start_job;
            chk("t2_dst", dst, 32'h2018);
            chk("t2_new_h", new_h, 3);
            chk("t2_new_w", new_w, 2);
            run_job(6);
            clear_intr;
        end

        // CCW 1 == CW 3 on the same 3x2 image.
        exp_wr = '{32'h2024, 32'h2018, 32'h2028, 32'h201C, 32'h202C, 32'h2020};
        for (int k = 0; k < 2; k++) begin
            mode = (k == 0) ? 2'd1 : 2'd3; dir = (k == 0); max_stall = 5;
            start_job;
            chk("t3_new_h", new_h, 2);
            chk("t3_new_w", new_w, 3);
            run_job(6);
            clear_intr;
        end
        max_stall = 0;

        // Zero-size job completes immediately with no traffic.
        src = 32'h4000; h = 16'd0; w = 16'd5; mode = 2'd1; dir = 1'b0;
        start_job;
        chk("z_done", done, 1);
        chk("z_rd_valid", rd_valid, 0);
        chk("z_new_h", new_h, 5);
        chk("z_new_w", new_w, 0);
        chk("z_dst", dst, 32'h4000);
        tick;
        chk("z_done_low", done, 0);
        chk("z_busy", busy, 0);
        chk("z_rd_valid2", rd_valid, 0);
        chk("z_wr_valid", wr_valid, 0);
        chk("z_intr", intr, 1);
        clear_intr;

        // Soft reset while pixel 2 waits for write acceptance.
        src = 32'h3000; h = 16'd2; w = 16'd3; mode = 2'd0; dir = 1'b0;
        exp_rd = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3014};
        exp_wr = '{32'h3018, 32'h301C, 32'h3020, 32'h3024, 32'h3028, 32'h302C};
        start_job;
        for (int i = 0; i < 2; i++) begin
            do_read(a);
            chk("sr_rd_addr", a, exp_rd[i]);
            do_write(exp_wr[i], exp_rd[i] ^ 32'hA5A5_0000);
        end
        do_read(a);
        chk("sr_rd_addr2", a, exp_rd[2]);
        chk("sr_wr_valid_pre", wr_valid, 1);
        srst = 1'b1;
        tick;
        chk("sr_wr_valid", wr_valid, 0);
        chk("sr_busy", busy, 0);
        chk("sr_done", done, 0);
        chk("sr_new_w_kept", new_w, 3);
        chk("sr_dst_kept", dst, 32'h3018);
        start = 1'b1; tick; start = 1'b0;
        chk("sr_start_ignored", busy, 0);
        srst = 1'b0;
        tick;
        chk("sr_no_done", done, 0);
        chk("sr_no_intr", intr, 0);
        start_job;
        chk("sr_restart_addr", rd_addr, 32'h3000);
        run_job(6);
        clear_intr;

        // Masked completion, then unmask.
        src = 32'h5000; h = 16'd1; w = 16'd1; mode = 2'd0; mask = 1'b1;
        exp_rd[0] = 32'h5000; exp_wr[0] = 32'h5004;
        start_job;
        run_job(1);
        chk("m_intr_masked", intr, 0);
        mask = 1'b0;
        #1;
        chk("m_intr_unmasked", intr, 1);
        clear_intr;

        // Clear coinciding with DONE: the set wins.
        start_job;
        do_read(a);
        do_write(32'h5004, 32'h5000 ^ 32'hA5A5_0000);
        tick;
        chk("c_done", done, 1);
        clr = 1'b1; tick; clr = 1'b0;
        chk("c_set_wins", intr, 1);
        clear_intr;

        // A second START while busy is ignored.
        src = 32'h6000; h = 16'd1; w = 16'd2;
        exp_rd[0] = 32'h6000; exp_rd[1] = 32'h6004;
        exp_wr[0] = 32'h6008; exp_wr[1] = 32'h600C;
        start_job;
        src = 32'h7000; h = 16'd4; w = 16'd4;
        start = 1'b1; tick; start = 1'b0;
        chk("b_new_w", new_w, 2);
        chk("b_dst", dst, 32'h6008);
        chk("b_rd_addr", rd_addr, 32'h6000);
        run_job(2);
        chk("b_intr", intr, 1);
        clear_intr;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rot_ctrl.md
# rot_ctrl

Rotation sequencer for the image-rotate engine. Takes the configuration and one-cycle start strobe produced by the APB register interface. Walks the source image in raster order, issuing one pixel read and one rotated-address write per pixel through valid/ready handshakes to the DMA port. Returns the rotated dimensions and destination base to the register interface, and raises a maskable completion interrupt.

## Interface

- ADDR_W, 32, address width
- DATA_W, 32, pixel width
- BPP_LOG2, 2, log2 bytes per pixel

- I_ROTCTRL_PCLK  in  1  clock
- I_ROTCTRL_PRESET_N  in  1  reset; one clock, reset is asynchronous and active-low
- I_ROTCTRL_START  in  1  start strobe (from CTRL_START bit)
- I_ROTCTRL_SOFT_RESET  in  1  synchronous abort (CTRL_RESET bit), level
- I_ROTCTRL_SRC_IMG  in  ADDR_W  source base byte address
- I_ROTCTRL_IMG_H / I_ROTCTRL_IMG_W  in  16  source height/width, pixels
- I_ROTCTRL_MODE  in  2  quarter turns 0..3
- I_ROTCTRL_DIR  in  1  0=clockwise, 1=counter-clockwise
- I_ROTCTRL_INTR_MASK  in  1  1 masks interrupt
- I_ROTCTRL_INTR_CLEAR  in  1  pulse, clears done flag
- O_ROTCTRL_RD_VALID / O_ROTCTRL_RD_ADDR  out  1 / ADDR_W  read request
- I_ROTCTRL_RD_READY  in  1  read request accepted
- I_ROTCTRL_RD_DVALID / I_ROTCTRL_RD_DATA  in  1 / DATA_W  read return
- O_ROTCTRL_WR_VALID / O_ROTCTRL_WR_ADDR / O_ROTCTRL_WR_DATA  out  1 / ADDR_W / DATA_W  write request
- I_ROTCTRL_WR_READY  in  1  write accepted
- O_ROTCTRL_DMA_DST_IMG  out  ADDR_W  destination base
- O_ROTCTRL_NEW_H / O_ROTCTRL_NEW_W  out  16  rotated dimensions
- O_ROTCTRL_BUSY  out  1  job in progress
- O_ROTCTRL_DONE  out  1  one-cycle completion pulse
- O_ROTCTRL_INTR  out  1  done_flag & ~INTR_MASK

## Operation

- Effective turns q = DIR ? (4-MODE)&3 : MODE.
- q odd: NEW_H=W, NEW_W=H. q even: NEW_H=H, NEW_W=W.
- Destination base DST = SRC + ((H*W) << BPP_LOG2), modulo 2^ADDR_W.
- On START in IDLE, latch SRC, H, W, q, NEW_H, NEW_W and DST. Latched values are held until the next accepted START.
- Source index (r,c): r 0..H-1 outer loop, c 0..W-1 inner loop.
- RD_ADDR = SRC + ((r*W+c) << BPP_LOG2).
- Destination (dr,dc) by q:
  - q=0: (r, c)
  - q=1: (c, H-1-r)
  - q=2: (H-1-r, W-1-c)
  - q=3: (W-1-c, r)
- WR_ADDR = DST + ((dr*NEW_W+dc) << BPP_LOG2). WR_DATA = captured RD_DATA.
- All products are computed at full width (32b) before the shift; the address sum is truncated to ADDR_W.
- FSM states:
  - IDLE: START → RD_REQ, or → DONE if H==0 or W==0.
  - RD_REQ: RD_VALID=1; on RD_READY → RD_WAIT.
  - RD_WAIT: on RD_DVALID capture data → WR_REQ.
  - WR_REQ: WR_VALID=1; on WR_READY → NEXT.
  - NEXT: advance (r,c); → DONE if last pixel, else → RD_REQ.
  - DONE: DONE=1, set done_flag → IDLE.
- START outside IDLE is ignored.
- INTR_CLEAR clears done_flag. If set and clear occur in the same cycle, set wins.
- SOFT_RESET=1 in any state: next state IDLE, valids drop, counters zero, done_flag cleared, no DONE pulse. Latched config and outputs are kept. While SOFT_RESET=1, START is ignored.
- BUSY=1 in every state except IDLE.

## Timing

- Async reset values:
  - FSM IDLE, all outputs 0, done_flag 0, counters 0.
  - DST/NEW_H/NEW_W = 0.
- START sampled at cycle T; RD_VALID high at T+1.
- RD_VALID and RD_ADDR are stable until accepted (RD_VALID & RD_READY on the same edge).
- WR_VALID, WR_ADDR and WR_DATA are stable until accepted (WR_VALID & WR_READY on the same edge).
- One pixel outstanding at a time; RD_DVALID is only expected in RD_WAIT and is ignored elsewhere.
- Minimum 4 cycles/pixel: READY high and DVALID one cycle after read acceptance.
- DONE pulses the cycle after the last write acceptance + NEXT.
- INTR rises the cycle after DONE and stays high until INTR_CLEAR.
- Zero-size job: DONE at T+1, no RD/WR traffic.
- O_ROTCTRL_DMA_DST_IMG/NEW_H/NEW_W update at T+1 and are stable while BUSY.

## Test plan

- SRC=0x1000, H=2, W=3, MODE=1, DIR=0, ready always 1:
  - DST=0x1018, NEW_H=3, NEW_W=2.
  - Reads at 0x1000..0x1014, step 4.
  - Writes at 0x101C, 0x1024, 0x102C, 0x1018, 0x1020, 0x1028 carrying the matching read data.
  - DONE after 6 pixels; INTR=1.
- MODE=2, DIR=1 vs MODE=2, DIR=0 on a 3x2 image: identical write address sequences. MODE=1, DIR=1 matches MODE=3, DIR=0.
- H=0, W=5, START: DONE at T+1, RD_VALID never asserted, NEW_H=5, NEW_W=0 (q=1).
- Random RD_READY/WR_READY/DVALID stalls of 0–5 cycles: address/data held stable while valid & ~ready, sequence unchanged, no duplicate or lost pixels.
- SOFT_RESET asserted during pixel 2 WR_REQ: WR_VALID=0 the next cycle, BUSY=0, no DONE pulse. A new START then runs a full job from pixel (0,0).
- INTR_MASK=1 at done: INTR=0. Unmask: INTR=1. INTR_CLEAR in the same cycle as DONE: flag remains 1. A later clear → INTR=0. A second START during BUSY is ignored.
